// File: rtl/div_32bit_seq.sv
// Sequential radix-2 restoring divider, one quotient bit per clock.
// Result layout: {remainder, quotient}. Signed mode truncates toward zero,
// and the remainder takes the dividend's sign.
// Optional macro DIV_ZERO_DETECT_EN: short-circuits zero divisors and adds a div_zero flag.
module div_32bit_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 clear_n,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result
`ifdef DIV_ZERO_DETECT_EN
  ,
  output logic                 div_zero
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         state, state_nxt;
  logic [WIDTH-1:0]   rem, rem_nxt;
  logic [WIDTH-1:0]   quo, quo_nxt;
  logic [WIDTH-1:0]   dvsr, dvsr_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               neg_q, neg_q_nxt;
  logic               neg_r, neg_r_nxt;
  logic               busy_nxt, done_nxt;
  logic [2*WIDTH-1:0] result_nxt;
`ifdef DIV_ZERO_DETECT_EN
  logic               div_zero_nxt;
`endif

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH+1:0]   trial;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Operand magnitudes and per-step trial subtraction; trial[WIDTH+1] is the borrow
  always_comb begin
    a_mag   = (is_signed && dividend[WIDTH-1]) ? (WIDTH'(0) - dividend) : dividend;
    b_mag   = (is_signed && divisor[WIDTH-1])  ? (WIDTH'(0) - divisor)  : divisor;
    trial   = {1'b0, rem, quo[WIDTH-1]} - {2'b00, dvsr};
    quo_fix = neg_q ? (WIDTH'(0) - quo) : quo;
    rem_fix = neg_r ? (WIDTH'(0) - rem) : rem;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_nxt  = state;
    rem_nxt    = rem;
    quo_nxt    = quo;
    dvsr_nxt   = dvsr;
    cnt_nxt    = cnt;
    neg_q_nxt  = neg_q;
    neg_r_nxt  = neg_r;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    result_nxt = result;
`ifdef DIV_ZERO_DETECT_EN
    div_zero_nxt = div_zero;
`endif

    case (state)
      S_IDLE, S_DONE: begin
        // DONE always falls back to idle; a start seen here is accepted directly
        if (state == S_DONE) begin
          state_nxt = S_IDLE;
          busy_nxt  = 1'b0;
        end
        if (start) begin
          state_nxt = S_CALC;
          busy_nxt  = 1'b1;
          quo_nxt   = a_mag;
          dvsr_nxt  = b_mag;
          rem_nxt   = '0;
          cnt_nxt   = '0;
          neg_q_nxt = is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          neg_r_nxt = is_signed && dividend[WIDTH-1];
`ifdef DIV_ZERO_DETECT_EN
          div_zero_nxt = 1'b0;
          if (divisor == '0) begin
            state_nxt    = S_DONE;
            busy_nxt     = 1'b0;
            done_nxt     = 1'b1;
            result_nxt   = {dividend, {WIDTH{1'b1}}};
            div_zero_nxt = 1'b1;
          end
`endif
        end
      end
      S_CALC: begin
        rem_nxt = trial[WIDTH+1] ? {rem[WIDTH-2:0], quo[WIDTH-1]} : trial[WIDTH-1:0];
        quo_nxt = {quo[WIDTH-2:0], ~trial[WIDTH+1]};
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == CNT_W'(WIDTH-1)) begin
          state_nxt = S_FIX;
        end
      end
      S_FIX: begin
        result_nxt = {rem_fix, quo_fix};
        state_nxt  = S_DONE;
        busy_nxt   = 1'b0;
        done_nxt   = 1'b1;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state  <= S_IDLE;
      rem    <= '0;
      quo    <= '0;
      dvsr   <= '0;
      cnt    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
`ifdef DIV_ZERO_DETECT_EN
      div_zero <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      rem    <= rem_nxt;
      quo    <= quo_nxt;
      dvsr   <= dvsr_nxt;
      cnt    <= cnt_nxt;
      neg_q  <= neg_q_nxt;
      neg_r  <= neg_r_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
      result <= result_nxt;
`ifdef DIV_ZERO_DETECT_EN
      div_zero <= div_zero_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_div_32bit_seq.sv
// Self-checking bench for div_32bit_seq: directed cases, randomized cases
// against an arithmetic reference model, busy-start, abort and back-to-back.
module tb_div_32bit_seq;

  logic        clock;
  logic        clear_n;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [63:0] result;
`ifdef DIV_ZERO_DETECT_EN
  logic        div_zero;
`endif

  int checks   = 0;
  int failures = 0;

  div_32bit_seq #(.WIDTH(32)) dut (
    .clock     (clock),
    .clear_n   (clear_n),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .result    (result)
`ifdef DIV_ZERO_DETECT_EN
    ,
    .div_zero  (div_zero)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference: plain integer division, truncating toward zero
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint la, lb, q, r;
    logic [31:0] qq, rr;
    if (b == 32'd0) begin
`ifdef DIV_ZERO_DETECT_EN
      return {a, 32'hFFFF_FFFF};
`else
      qq = (s && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
      return {a, qq};
`endif
    end
    if (s) begin
      la = int'(a);
      lb = int'(b);
      q  = la / lb;
      r  = la % lb;
      qq = q[31:0];
      rr = r[31:0];
    end else begin
      qq = a / b;
      rr = a % b;
    end
    return {rr, qq};
  endfunction

  function automatic int exp_lat(input logic [31:0] b);
`ifdef DIV_ZERO_DETECT_EN
    if (b == 32'd0) return 1;
`endif
    return 34;
  endfunction

  function automatic int exp_busy(input logic [31:0] b);
`ifdef DIV_ZERO_DETECT_EN
    if (b == 32'd0) return 0;
`endif
    return 33;
  endfunction

  // Issue one divide, scramble inputs after acceptance, wait (bounded) for done
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [63:0] res, output int lat, output int bcnt);
    @(negedge clock);
    dividend  = a;
    divisor   = b;
    is_signed = s;
    start     = 1'b1;
    @(posedge clock);
    #1;
    start     = 1'b0;
    dividend  = $urandom;
    divisor   = $urandom;
    is_signed = 1'($urandom_range(0, 1));
    lat  = 0;
    bcnt = 0;
    res  = '0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clock);
      if (busy) bcnt++;
      if (done) begin
        lat = n;
        res = result;
        break;
      end
    end
  endtask

  task automatic test_reset();
    clear_n   = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    #3;
    clear_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
    checks++;
    if (result !== 64'd0) begin failures++; $display("FAIL reset_result got=%h want=0", result); end
`ifdef DIV_ZERO_DETECT_EN
    checks++;
    if (div_zero !== 1'b0) begin failures++; $display("FAIL reset_div_zero got=%b want=0", div_zero); end
`endif
    repeat (3) @(negedge clock);
    clear_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] ta [5];
    logic [31:0] tb [5];
    logic        ts [5];
    logic [63:0] te [5];
    logic [63:0] res, held;
    int lat, bcnt;
    ta[0] = 32'd100;        tb[0] = 32'd7;          ts[0] = 1'b1; te[0] = {32'd2, 32'd14};
    ta[1] = -32'sd100;      tb[1] = 32'd7;          ts[1] = 1'b1; te[1] = {32'hFFFF_FFFE, 32'hFFFF_FFF2};
    ta[2] = 32'd7;          tb[2] = -32'sd100;      ts[2] = 1'b1; te[2] = {32'd7, 32'd0};
    ta[3] = 32'h8000_0000;  tb[3] = 32'hFFFF_FFFF;  ts[3] = 1'b1; te[3] = {32'd0, 32'h8000_0000};
    ta[4] = 32'hFFFF_FFFF;  tb[4] = 32'd2;          ts[4] = 1'b0; te[4] = {32'd1, 32'h7FFF_FFFF};
    for (int i = 0; i < 5; i++) begin
      run_div(ta[i], tb[i], ts[i], res, lat, bcnt);
      checks++;
      if (res !== te[i]) begin failures++; $display("FAIL directed_result[%0d] got=%h want=%h", i, res, te[i]); end
      checks++;
      if (lat !== 34) begin failures++; $display("FAIL directed_latency[%0d] got=%0d want=34", i, lat); end
      checks++;
      if (bcnt !== 33) begin failures++; $display("FAIL directed_busy_cycles[%0d] got=%0d want=33", i, bcnt); end
      held = res;
      @(negedge clock);
      checks++;
      if (done !== 1'b0) begin failures++; $display("FAIL directed_done_pulse[%0d] got=%b want=0", i, done); end
      repeat (3) @(negedge clock);
      checks++;
      if (result !== held) begin failures++; $display("FAIL directed_result_held[%0d] got=%h want=%h", i, result, held); end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic s;
    logic [63:0] res, exp;
    int lat, bcnt;
    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0:       b = $urandom;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'd0 - 32'($urandom_range(1, 15));
        3:       b = 32'd0;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      exp = model(a, b, s);
      run_div(a, b, s, res, lat, bcnt);
      checks++;
      if (res !== exp) begin
        failures++;
        $display("FAIL random_result[%0d] a=%h b=%h s=%b got=%h want=%h", i, a, b, s, res, exp);
      end
      checks++;
      if (lat !== exp_lat(b)) begin failures++; $display("FAIL random_latency[%0d] got=%0d want=%0d", i, lat, exp_lat(b)); end
      checks++;
      if (bcnt !== exp_busy(b)) begin failures++; $display("FAIL random_busy[%0d] got=%0d want=%0d", i, bcnt, exp_busy(b)); end
    end
  endtask

  task automatic test_start_while_busy();
    int lat;
    logic [63:0] res;
    @(negedge clock);
    dividend = 32'd1000; divisor = 32'd3; is_signed = 1'b0; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    lat = 0;
    res = '0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clock);
      if (n == 10) begin start = 1'b1; dividend = 32'd5; divisor = 32'd5; end
      if (n == 11) start = 1'b0;
      if (done) begin lat = n; res = result; break; end
    end
    checks++;
    if (res !== {32'd1, 32'd333}) begin failures++; $display("FAIL busy_start_result got=%h want=%h", res, {32'd1, 32'd333}); end
    checks++;
    if (lat !== 34) begin failures++; $display("FAIL busy_start_latency got=%0d want=34", lat); end
  endtask

  task automatic test_abort();
    bit saw_done;
    logic [63:0] res;
    int lat, bcnt;
    @(negedge clock);
    dividend = 32'd1000; divisor = 32'd3; is_signed = 1'b0; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    saw_done = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clock);
      if (done) saw_done = 1'b1;
      if (n == 10) begin start = 1'b1; dividend = 32'd5; divisor = 32'd5; end
      if (n == 11) start = 1'b0;
    end
    clear_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b want=0", busy); end
    checks++;
    if (result !== 64'd0) begin failures++; $display("FAIL abort_result got=%h want=0", result); end
    repeat (2) @(negedge clock);
    clear_n = 1'b1;
    repeat (40) begin
      @(negedge clock);
      if (done || busy) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin failures++; $display("FAIL abort_no_done got=%b want=0", saw_done); end
    run_div(32'd5, 32'd5, 1'b0, res, lat, bcnt);
    checks++;
    if (res !== {32'd0, 32'd1}) begin failures++; $display("FAIL abort_fresh_result got=%h want=%h", res, {32'd0, 32'd1}); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] r1, r2;
    int l1, l2;
    @(negedge clock);
    dividend = 32'd9; divisor = 32'd4; is_signed = 1'b1; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    l1 = 0; r1 = '0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clock);
      if (done) begin l1 = n; r1 = result; break; end
    end
    // Issue the second divide while done is high
    dividend = 32'd20; divisor = 32'd6; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    l2 = 0; r2 = '0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clock);
      if (done) begin l2 = n; r2 = result; break; end
    end
    checks++;
    if (r1 !== {32'd1, 32'd2}) begin failures++; $display("FAIL b2b_first_result got=%h want=%h", r1, {32'd1, 32'd2}); end
    checks++;
    if (r2 !== {32'd2, 32'd3}) begin failures++; $display("FAIL b2b_second_result got=%h want=%h", r2, {32'd2, 32'd3}); end
    checks++;
    if (l1 !== 34) begin failures++; $display("FAIL b2b_first_latency got=%0d want=34", l1); end
    checks++;
    if (l2 !== 34) begin failures++; $display("FAIL b2b_done_spacing got=%0d want=34", l2); end
  endtask

  task automatic test_zero_div();
    logic [63:0] res;
    int lat, bcnt;
    run_div(32'd50, 32'd0, 1'b1, res, lat, bcnt);
    checks++;
    if (res !== {32'd50, 32'hFFFF_FFFF}) begin failures++; $display("FAIL zero_result got=%h want=%h", res, {32'd50, 32'hFFFF_FFFF}); end
`ifdef DIV_ZERO_DETECT_EN
    checks++;
    if (lat !== 1) begin failures++; $display("FAIL zero_latency got=%0d want=1", lat); end
    checks++;
    if (div_zero !== 1'b1) begin failures++; $display("FAIL zero_flag got=%b want=1", div_zero); end
    run_div(32'd50, 32'd5, 1'b1, res, lat, bcnt);
    checks++;
    if (div_zero !== 1'b0) begin failures++; $display("FAIL zero_flag_clear got=%b want=0", div_zero); end
`else
    checks++;
    if (lat !== 34) begin failures++; $display("FAIL zero_latency got=%0d want=34", lat); end
    run_div(-32'sd50, 32'd0, 1'b1, res, lat, bcnt);
    checks++;
    if (res !== {32'hFFFF_FFCE, 32'd1}) begin failures++; $display("FAIL zero_neg_result got=%h want=%h", res, {32'hFFFF_FFCE, 32'd1}); end
`endif
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_while_busy();
    test_abort();
    test_back_to_back();
    test_zero_div();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
